// File: rtl/unpack_pkg.sv
// Shared definitions for the 7-bit <-> 32-bit packer/unpacker pair.
// DATA_PACK_STATS_EN (see data_pack) does not affect this package.
package unpack_pkg;

  localparam int VAL_W  = 7;
  localparam int WORD_W = 32;
  localparam int ACC_W  = 38;
  localparam int CNT_W  = 6;

  localparam logic [CNT_W-1:0] VAL_CNT  = 6'd7;
  localparam logic [CNT_W-1:0] WORD_CNT = 6'd32;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic              sop;
    logic              eop;
  } word_t;

  // Keeps the low n bits of a word; n >= 32 keeps everything.
  function automatic logic [WORD_W-1:0] lowMask(input logic [CNT_W-1:0] n);
    if (n >= WORD_CNT) lowMask = '1;
    else               lowMask = ~({WORD_W{1'b1}} << n);
  endfunction

endpackage

// File: rtl/data_pack_oreg.sv
// Output register stage for data_pack: holds one framed word until the
// downstream side takes it.
module data_pack_oreg
  import unpack_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [WORD_W-1:0] i_data,
  input  logic              i_sop,
  input  logic              i_eop,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [WORD_W-1:0] o_data,
  output logic              o_sop,
  output logic              o_eop,
  output logic              o_slotFree
);

  logic              r_valid;
  logic              r_sop;
  logic              r_eop;
  logic [WORD_W-1:0] r_data;

  // Load only happens when the slot is free, so a stalled word is never overwritten.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_sop   <= i_sop;
      r_eop   <= i_eop;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
    end
  end

  assign o_valid    = r_valid;
  assign o_data     = r_data;
  assign o_sop      = r_sop;
  assign o_eop      = r_eop;
  assign o_slotFree = !r_valid || i_ready;

endmodule

// File: rtl/data_pack.sv
// Packs 7-bit values LSB-first into 32-bit words with sop/eop framing.
// Define DATA_PACK_STATS_EN to add the pkt_cnt/err_cnt statistics ports.
module data_pack #(
  parameter int VAL_W  = unpack_pkg::VAL_W,
  parameter int WORD_W = unpack_pkg::WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready_out,
  input  logic              valid_in,
  input  logic [VAL_W-1:0]  data_in,
  input  logic              sop_in,
  input  logic              eop_in,
  output logic              valid_out,
  output logic [WORD_W-1:0] data_out,
  output logic              sop_out,
  output logic              eop_out,
`ifdef DATA_PACK_STATS_EN
  output logic [15:0]       pkt_cnt,
  output logic [15:0]       err_cnt,
`endif
  input  logic              ready_in
);

  import unpack_pkg::*;

  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_inPkt;
  logic             r_first;
  logic             r_flush;

  logic             w_accept;
  logic             w_slotFree;
  logic             w_emit;
  logic [ACC_W-1:0] w_acc1;
  logic [ACC_W-1:0] w_acc2;
  logic [CNT_W-1:0] w_cnt1;
  logic [CNT_W-1:0] w_cnt2;
  logic             w_inPkt1;
  logic             w_first1;
  logic             w_flush1;
  word_t            w_word;

  assign ready_out = (r_cnt < WORD_CNT) && !r_flush;
  assign w_accept  = valid_in && ready_out;

  // Accept first, then decide on an emit from the post-accept state so a
  // completing value reaches valid_out one cycle later.
  always_comb begin
    w_acc1   = r_acc;
    w_cnt1   = r_cnt;
    w_inPkt1 = r_inPkt;
    w_first1 = r_first;
    w_flush1 = r_flush;
    if (w_accept) begin
      if (sop_in) begin
        w_acc1   = ACC_W'(data_in);
        w_cnt1   = VAL_CNT;
        w_inPkt1 = 1'b1;
        w_first1 = 1'b1;
      end else if (r_inPkt) begin
        w_acc1 = r_acc | (ACC_W'(data_in) << r_cnt);
        w_cnt1 = r_cnt + VAL_CNT;
      end
      if (eop_in && (sop_in || r_inPkt)) begin
        w_flush1 = 1'b1;
        w_inPkt1 = 1'b0;
      end
    end

    w_emit = w_slotFree && ((w_cnt1 >= WORD_CNT) || w_flush1);

    w_acc2 = w_acc1;
    w_cnt2 = w_cnt1;
    if (w_emit) begin
      w_acc2 = w_acc1 >> WORD_W;
      w_cnt2 = (w_cnt1 >= WORD_CNT) ? (w_cnt1 - WORD_CNT) : '0;
    end

    w_word.data = w_acc1[WORD_W-1:0] & lowMask(w_cnt1);
    w_word.sop  = w_first1;
    w_word.eop  = w_flush1 && (w_cnt2 == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_inPkt <= 1'b0;
      r_first <= 1'b0;
      r_flush <= 1'b0;
    end else begin
      r_acc   <= w_acc2;
      r_cnt   <= w_cnt2;
      r_inPkt <= w_inPkt1;
      r_first <= w_emit ? 1'b0 : w_first1;
      r_flush <= (w_emit && w_word.eop) ? 1'b0 : w_flush1;
    end
  end

  data_pack_oreg u_oreg (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_emit),
    .i_data     (w_word.data),
    .i_sop      (w_word.sop),
    .i_eop      (w_word.eop),
    .i_ready    (ready_in),
    .o_valid    (valid_out),
    .o_data     (data_out),
    .o_sop      (sop_out),
    .o_eop      (eop_out),
    .o_slotFree (w_slotFree)
  );

`ifdef DATA_PACK_STATS_EN
  logic [15:0] r_pktCnt;
  logic [15:0] r_errCnt;
  logic        w_errEvent;

  // A sop inside a packet and a value outside any packet are both protocol errors.
  assign w_errEvent = w_accept && (sop_in ? r_inPkt : !r_inPkt);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pktCnt <= '0;
      r_errCnt <= '0;
    end else begin
      if (w_emit && w_word.eop) r_pktCnt <= r_pktCnt + 16'd1;
      if (w_errEvent && (r_errCnt != 16'hFFFF)) r_errCnt <= r_errCnt + 16'd1;
    end
  end

  assign pkt_cnt = r_pktCnt;
  assign err_cnt = r_errCnt;
`else
  // Without statistics, stray values and duplicate sops are absorbed silently.
`endif

endmodule

// File: tb/tb_data_pack.sv
// Scoreboard bench for data_pack; also checks statistics when
// DATA_PACK_STATS_EN is defined.
module tb_data_pack;

  import unpack_pkg::*;

  logic        clk;
  logic        rst;
  logic        ready_out;
  logic        valid_in;
  logic [6:0]  data_in;
  logic        sop_in;
  logic        eop_in;
  logic        valid_out;
  logic [31:0] data_out;
  logic        sop_out;
  logic        eop_out;
  logic        ready_in;
`ifdef DATA_PACK_STATS_EN
  logic [15:0] pktCnt;
  logic [15:0] errCnt;
`endif

  int    checks = 0;
  int    fails  = 0;
  word_t expQ[$];

  data_pack dut (
    .clk       (clk),
    .rst       (rst),
    .ready_out (ready_out),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .sop_in    (sop_in),
    .eop_in    (eop_in),
    .valid_out (valid_out),
    .data_out  (data_out),
    .sop_out   (sop_out),
    .eop_out   (eop_out),
`ifdef DATA_PACK_STATS_EN
    .pkt_cnt   (pktCnt),
    .err_cnt   (errCnt),
`endif
    .ready_in  (ready_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pushExpected(input logic [31:0] d, input logic s, input logic e);
    word_t w;
    w.data = d;
    w.sop  = s;
    w.eop  = e;
    expQ.push_back(w);
  endtask

  // Called at a negedge; returns at the negedge after the value transferred.
  task automatic applyStimulus(input logic [6:0] d, input logic s, input logic e);
    int guard = 0;
    valid_in = 1'b1;
    data_in  = d;
    sop_in   = s;
    eop_in   = e;
    while (!ready_out && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      checks++;
      fails++;
      $display("[TB] FAIL accept_timeout: ready_out stayed %b for value %h", ready_out, d);
    end
    @(negedge clk);
    valid_in = 1'b0;
    sop_in   = 1'b0;
    eop_in   = 1'b0;
  endtask

  task automatic waitDrain();
    int guard = 0;
    while (expQ.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      checks++;
      fails++;
      $display("[TB] FAIL drain_timeout: %0d words outstanding, expected 0", expQ.size());
    end
    repeat (2) @(negedge clk);
  endtask

  // Monitor: sampled mid-low-phase, well away from the rising edge.
  initial begin
    logic  pStall;
    word_t prev;
    word_t e;
    pStall = 1'b0;
    prev   = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        pStall = 1'b0;
      end else begin
        if (pStall) begin
          checkOutput("hold_valid", 32'(valid_out), 32'd1);
          checkOutput("hold_data", data_out, prev.data);
          checkOutput("hold_sop", 32'(sop_out), 32'(prev.sop));
          checkOutput("hold_eop", 32'(eop_out), 32'(prev.eop));
        end
        if (valid_out && ready_in) begin
          if (expQ.size() == 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL unexpected_word: got %h sop %b eop %b, expected none", data_out, sop_out, eop_out);
          end else begin
            e = expQ.pop_front();
            checkOutput("word_data", data_out, e.data);
            checkOutput("word_sop", 32'(sop_out), 32'(e.sop));
            checkOutput("word_eop", 32'(eop_out), 32'(e.eop));
          end
        end
        pStall    = valid_out && !ready_in;
        prev.data = data_out;
        prev.sop  = sop_out;
        prev.eop  = eop_out;
      end
    end
  end

  initial begin
    rst      = 1'b1;
    valid_in = 1'b0;
    data_in  = '0;
    sop_in   = 1'b0;
    eop_in   = 1'b0;
    ready_in = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_ready_out", 32'(ready_out), 32'd1);
    checkOutput("rst_valid_out", 32'(valid_out), 32'd0);
    checkOutput("rst_data_out", data_out, 32'd0);
    checkOutput("rst_sop_out", 32'(sop_out), 32'd0);
    checkOutput("rst_eop_out", 32'(eop_out), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic packing with a 3-bit residue closed by an eop value.
    pushExpected(32'hF00C_C05A, 1'b1, 1'b0);
    pushExpected(32'h0000_000F, 1'b0, 1'b1);
    applyStimulus(7'h5A, 1'b1, 1'b0);
    applyStimulus(7'h00, 1'b0, 1'b0);
    applyStimulus(7'h33, 1'b0, 1'b0);
    applyStimulus(7'h00, 1'b0, 1'b0);
    applyStimulus(7'h7F, 1'b0, 1'b0);
    checkOutput("latency_valid", 32'(valid_out), 32'd1);
    checkOutput("latency_data", data_out, 32'hF00C_C05A);
    applyStimulus(7'h01, 1'b0, 1'b1);

    // Single-value packet.
    pushExpected(32'h0000_005A, 1'b1, 1'b1);
    applyStimulus(7'h5A, 1'b1, 1'b1);
    checkOutput("single_ready_kept", 32'(ready_out), 32'd1);

    // 224 bits: seven full words, then the next packet without a gap.
    for (int i = 0; i < 7; i++) pushExpected(32'hFFFF_FFFF, i == 0, i == 6);
    for (int i = 0; i < 32; i++) applyStimulus(7'h7F, i == 0, i == 31);
    checkOutput("aligned_eop_no_gap", 32'(ready_out), 32'd1);

    // 35-bit packet: two words, one dead cycle.
    pushExpected(32'hF080_C101, 1'b1, 1'b0);
    pushExpected(32'h0000_0007, 1'b0, 1'b1);
    applyStimulus(7'h01, 1'b1, 1'b0);
    applyStimulus(7'h02, 1'b0, 1'b0);
    applyStimulus(7'h03, 1'b0, 1'b0);
    applyStimulus(7'h04, 1'b0, 1'b0);
    applyStimulus(7'h7F, 1'b0, 1'b1);
    checkOutput("overflow_eop_ready_low", 32'(ready_out), 32'd0);
    @(negedge clk);
    checkOutput("overflow_eop_ready_back", 32'(ready_out), 32'd1);
    waitDrain();

    // Backpressure: downstream stalls for 10 cycles during a 70-bit packet.
    pushExpected(32'h5080_C101, 1'b1, 1'b0);
    pushExpected(32'h0910_1C30, 1'b0, 1'b0);
    pushExpected(32'h0000_0005, 1'b0, 1'b1);
    ready_in = 1'b0;
    fork
      begin
        repeat (10) @(negedge clk);
        checkOutput("stall_ready_low", 32'(ready_out), 32'd0);
        ready_in = 1'b1;
      end
      begin
        for (int k = 1; k <= 10; k++) applyStimulus(7'(k), k == 1, k == 10);
      end
    join
    waitDrain();

    // Stray values outside a packet, then a sop that abandons a partial packet.
    applyStimulus(7'h15, 1'b0, 1'b0);
    applyStimulus(7'h16, 1'b0, 1'b1);
    pushExpected(32'h0000_0003, 1'b1, 1'b1);
    applyStimulus(7'h11, 1'b1, 1'b0);
    applyStimulus(7'h22, 1'b0, 1'b0);
    applyStimulus(7'h03, 1'b1, 1'b1);
    waitDrain();
`ifdef DATA_PACK_STATS_EN
    checkOutput("stats_pkt_cnt", 32'(pktCnt), 32'd6);
    checkOutput("stats_err_cnt", 32'(errCnt), 32'd3);
`endif

    // Reset mid-packet drops the partial word.
    applyStimulus(7'h44, 1'b1, 1'b0);
    applyStimulus(7'h55, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_ready_out", 32'(ready_out), 32'd1);
    checkOutput("midrst_valid_out", 32'(valid_out), 32'd0);
    pushExpected(32'h0000_0012, 1'b1, 1'b1);
    applyStimulus(7'h12, 1'b1, 1'b1);
    waitDrain();
`ifdef DATA_PACK_STATS_EN
    checkOutput("midrst_pkt_cnt", 32'(pktCnt), 32'd1);
    checkOutput("midrst_err_cnt", 32'(errCnt), 32'd0);
`endif

    repeat (5) @(negedge clk);
    checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/data_pack.md
Name: data_pack

Overview:
- Packs a stream of 7-bit values into LSB-aligned 32-bit words, LSB-first. It is the transmit-side counterpart of the 32-to-7 unpacker.
- Packet framing (sop/eop) is carried from input values to output words.
- The last word of a packet is zero-padded.
- Sits upstream of any 32-bit word link whose far end unpacks back to 7-bit values.

Parameters:
- VAL_W, 7, input value width (fixed by protocol; parameter for readability only).
- WORD_W, 32, output word width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- ready_out  out  1  room to accept a value this cycle.
- valid_in  in  1  value transferred when valid_in && ready_out.
- data_in  in  7  input value.
- sop_in  in  1  first value of a packet.
- eop_in  in  1  last value of a packet.
- valid_out  out  1  word presented.
- data_out  out  32  packed word.
- sop_out  out  1  first word of a packet.
- eop_out  out  1  last word of a packet.
- ready_in  in  1  downstream accepts the word when valid_out && ready_in.

Behaviour:
- Reset state: all outputs 0 except ready_out=1. acc=0, cnt=0, in_pkt=0, flush=0, first=0.
- State held:
  - acc[37:0] and cnt[5:0], range 0..38.
  - Output register: data/sop/eop/valid.
  - Flags in_pkt, first, flush.
- ready_out = (cnt < 32) && !flush. Registered state only; no combinational path from ready_in.
- Accept rules:
  - Accepted with sop_in: acc = data_in, cnt = 7, in_pkt=1, first=1. Any residue from an unterminated packet is discarded and no eop is emitted for it.
  - Accepted without sop_in while in_pkt: data_in is ORed in at bit position cnt; cnt += 7.
  - Accepted while !in_pkt and !sop_in: value is discarded; ready_out stays 1.
- Word emit:
  - An emit happens when the output slot is free (!valid_out || ready_in) and either next-cnt ≥ 32 or next-flush is set.
  - The emitted word is acc[31:0] of the next-state accumulator, with bits ≥ cnt zeroed when cnt < 32.
  - After emit: acc >>= 32 and cnt -= min(cnt, 32).
  - Latency: the value completing a word is accepted in cycle N; valid_out is high in cycle N+1.
- sop_out = first on the emitted word; first is cleared after that emit.
- Packet end:
  - eop_in accepted: flush=1 and in_pkt=0.
  - eop_out=1 on the emit that leaves cnt==0; flush is then cleared.
  - If cnt > 32 at eop, two words go out on consecutive cycles and ready_out is low for exactly one cycle.
  - Otherwise there are zero dead cycles between packets.
- sop_in && eop_in on the same value: one word with sop_out=eop_out=1.
- Backpressure:
  - While valid_out && !ready_in, all outputs are held stable.
  - If cnt ≥ 32, ready_out drops until the slot drains.
- rst mid-packet: all state cleared the next edge; partial words are lost.

Optional Feature:
- DATA_PACK_STATS_EN defined:
  - Adds output ports pkt_cnt[15:0] (eop words emitted, wraps) and err_cnt[15:0].
  - err_cnt counts sop_in while in_pkt, plus values dropped outside a packet. It saturates at 0xFFFF.
  - Both counters are reset to 0.
- Macro undefined: ports absent, no logic.

Decomposition:
- Shared package unpack_pkg holds VAL_W=7, WORD_W=32 and ACC_W=38, common with the unpacker.
- No sub-module required. The output register stage may be split as data_pack_oreg if reuse is wanted.

Test Plan:
- sop value 7'h5A, then 7'h00, 7'h33, 7'h00, 7'h7F; ready_in=1 -> data_out=32'hF00C_C05A with sop_out=1 one cycle after the fifth value, leaving cnt=3 residue 3'b111.
- Single value 7'h5A with sop_in=eop_in=1 -> data_out=32'h0000_005A, sop_out=eop_out=1; ready_out never drops.
- 32 consecutive values 7'h7F (224 bits) -> 7 words of 32'hFFFF_FFFF, sop on the first, eop on the seventh. The next packet's sop is accepted the cycle after eop with no gap.
- 5-value packet whose last value has eop (35 bits) -> full word, then word 32'h0000_0007 with eop_out. ready_out low for exactly 1 cycle.
- ready_in=0 for 10 cycles mid-packet -> data_out stable; ready_out low once cnt ≥ 32; no value lost or duplicated after release.
- Values without sop after eop, then sop mid-packet -> stray values dropped, new packet starts cleanly; with DATA_PACK_STATS_EN, err_cnt increments by the matching count.
